// File: rtl/note_player_pkg.sv
// note_player_pkg: shared widths, rates, FSM state type and the note-to-step
// table generator used by note_step_rom.
package note_player_pkg;

    localparam int unsigned NOTE_W      = 6;
    localparam int unsigned DUR_W       = 6;
    localparam int unsigned STEP_W      = 20;
    localparam int unsigned SAMPLE_RATE = 48000;
    localparam int unsigned BEAT_RATE   = 48;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    // Phase increment for note n: round(440 * 2^((n-49)/12) * 2^20 / SAMPLE_RATE).
    // The base table holds the octave n = 49..60 with 8 fraction bits; other
    // octaves are reached by shifting, rounding once at the end. n = 0 is a rest.
    function automatic int unsigned rom_entry(input int unsigned n);
        int unsigned idx;
        int unsigned semi;
        int unsigned shift;
        int unsigned base;
        if (n == 0 || n > 63) begin
            return 0;
        end
        idx   = n + 11;           // (n - 49) + 60, keeps octave arithmetic unsigned
        semi  = idx % 12;
        shift = 13 - (idx / 12);  // 8 fraction bits minus octave offset
        case (semi)
            0:       base = 2460658;
            1:       base = 2606977;
            2:       base = 2761996;
            3:       base = 2926232;
            4:       base = 3100235;
            5:       base = 3284585;
            6:       base = 3479896;
            7:       base = 3686822;
            8:       base = 3906052;
            9:       base = 4138318;
            10:      base = 4384395;
            default: base = 4645104;
        endcase
        return (base + (32'd1 << (shift - 1))) >> shift;
    endfunction

endpackage

// File: rtl/note_step_rom.sv
// note_step_rom: combinational lookup from note number to phase increment.
// Ports: note (address), step (phase increment, 0 for a rest).
module note_step_rom #(
    parameter int unsigned NOTE_W = note_player_pkg::NOTE_W,
    parameter int unsigned STEP_W = note_player_pkg::STEP_W
) (
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);
    import note_player_pkg::*;

    localparam int unsigned DEPTH = 32'(2 ** NOTE_W);

    logic [STEP_W-1:0] rom_mem [DEPTH];

    // Contents are elaboration-time constants.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom_mem[g] = STEP_W'(rom_entry(32'(g)));
    end

    assign step = rom_mem[note];

endmodule

// File: rtl/note_player.sv
// note_player: plays one song-ROM note at a time. Latches the note's phase
// increment, counts `duration` enabled beats, then pulses note_done.
// Ports: clk, reset (sync, active-high), play_enable (pause when low),
//   load_new_note/note/duration (note strobe from the song ROM), beat (48 Hz
//   tick), step_size (phase increment, muted while paused), new_frequency
//   (step changed), note_done (note finished), busy (note in progress).
module note_player #(
    parameter int unsigned NOTE_W = note_player_pkg::NOTE_W,
    parameter int unsigned DUR_W  = note_player_pkg::DUR_W,
    parameter int unsigned STEP_W = note_player_pkg::STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic              load_new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic              beat,
    output logic [STEP_W-1:0] step_size,
    output logic              new_frequency,
    output logic              note_done,
    output logic              busy
);
    import note_player_pkg::*;

    state_t            state;
    logic [DUR_W-1:0]  remaining;
    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] rom_step;

    note_step_rom #(
        .NOTE_W (NOTE_W),
        .STEP_W (STEP_W)
    ) u_rom (
        .note (note),
        .step (rom_step)
    );

    // FSM, beat counter and step register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remaining     <= '0;
            step_reg      <= '0;
            new_frequency <= 1'b0;
            note_done     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            new_frequency <= 1'b0;
            note_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_new_note) begin
                        if (duration != '0) begin
                            remaining     <= duration;
                            step_reg      <= rom_step;
                            new_frequency <= 1'b1;
                            busy          <= 1'b1;
                            state         <= PLAYING;
                        end else begin
                            // Zero-length note finishes immediately, step untouched.
                            note_done <= 1'b1;
                        end
                    end
                end
                PLAYING: begin
                    // Loads are ignored here; paused beats are not counted.
                    if (beat && play_enable) begin
                        if (remaining == DUR_W'(1)) begin
                            step_reg  <= '0;
                            note_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            remaining <= remaining - DUR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pause mutes without waiting for a clock edge.
    assign step_size = play_enable ? step_reg : '0;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed self-checking bench for note_player.
module tb_note_player;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;
    localparam int unsigned STEP_W = 20;

    logic              clk;
    logic              reset;
    logic              play_enable;
    logic              load_new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              beat;
    logic [STEP_W-1:0] step_size;
    logic              new_frequency;
    logic              note_done;
    logic              busy;

    int tests = 0;
    int fails = 0;

    // Pulse bookkeeping, sampled mid-cycle.
    int   nd_total   = 0;
    int   nd_wide    = 0;
    int   collide    = 0;
    logic nd_prev    = 1'b0;

    note_player #(
        .NOTE_W (NOTE_W),
        .DUR_W  (DUR_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .play_enable   (play_enable),
        .load_new_note (load_new_note),
        .note          (note),
        .duration      (duration),
        .beat          (beat),
        .step_size     (step_size),
        .new_frequency (new_frequency),
        .note_done     (note_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_done) nd_total++;
        if (note_done && nd_prev) nd_wide++;
        if (note_done && new_frequency) collide++;
        nd_prev = note_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic load(input int unsigned n, input int unsigned d);
        note          = NOTE_W'(n);
        duration      = DUR_W'(d);
        load_new_note = 1'b1;
        tick();
        load_new_note = 1'b0;
    endtask

    initial begin
        int base;
        reset         = 1'b1;
        play_enable   = 1'b1;
        load_new_note = 1'b0;
        note          = '0;
        duration      = '0;
        beat          = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_step", 32'(step_size), 0);
        check("reset_nf", 32'(new_frequency), 0);
        check("reset_nd", 32'(note_done), 0);
        check("reset_busy", 32'(busy), 0);

        // Note 49 for 3 beats; a beat in the load cycle is not counted.
        beat = 1'b1;
        load(49, 3);
        beat = 1'b0;
        check("a49_step", 32'(step_size), 9612);
        check("a49_nf", 32'(new_frequency), 1);
        check("a49_busy", 32'(busy), 1);
        tick();
        check("a49_nf_once", 32'(new_frequency), 0);
        do_beat();
        do_beat();
        check("a49_nd_early", 32'(note_done), 0);
        do_beat();
        check("a49_nd", 32'(note_done), 1);
        check("a49_step_off", 32'(step_size), 0);
        check("a49_busy_off", 32'(busy), 0);
        tick();
        check("a49_nd_once", 32'(note_done), 0);

        // Rest, 2 beats.
        load(0, 2);
        check("rest_step", 32'(step_size), 0);
        check("rest_busy", 32'(busy), 1);
        do_beat();
        check("rest_nd_early", 32'(note_done), 0);
        do_beat();
        check("rest_nd", 32'(note_done), 1);

        // Note 37 for 4 beats with two paused beats in the middle.
        load(37, 4);
        check("pause_step", 32'(step_size), 4806);
        do_beat();
        play_enable = 1'b0;
        #1;
        check("pause_muted", 32'(step_size), 0);
        do_beat();
        do_beat();
        check("pause_busy", 32'(busy), 1);
        check("pause_nd", 32'(note_done), 0);
        play_enable = 1'b1;
        #1;
        check("pause_resume", 32'(step_size), 4806);
        do_beat();
        do_beat();
        check("pause_nd_early", 32'(note_done), 0);
        do_beat();
        check("pause_nd", 32'(note_done), 1);

        // Loads while playing and on the final beat are ignored.
        load(61, 2);
        check("ign_step", 32'(step_size), 19224);
        load(49, 5);
        check("ign_step_kept", 32'(step_size), 19224);
        check("ign_nf", 32'(new_frequency), 0);
        do_beat();
        check("ign_nd_early", 32'(note_done), 0);
        beat = 1'b1;
        load(37, 9);
        beat = 1'b0;
        check("final_nd", 32'(note_done), 1);
        check("final_nf", 32'(new_frequency), 0);
        check("final_step", 32'(step_size), 0);
        check("final_busy", 32'(busy), 0);
        // Load on the note_done cycle is accepted.
        load(49, 1);
        check("b2b_nf", 32'(new_frequency), 1);
        check("b2b_step", 32'(step_size), 9612);
        check("b2b_nd", 32'(note_done), 0);
        do_beat();
        check("b2b_done", 32'(note_done), 1);

        // Duration 0.
        tick();
        load(5, 0);
        check("dur0_nd", 32'(note_done), 1);
        check("dur0_nf", 32'(new_frequency), 0);
        check("dur0_busy", 32'(busy), 0);
        check("dur0_step", 32'(step_size), 0);
        tick();
        check("dur0_nd_once", 32'(note_done), 0);

        // Lowest note, then reset after 1 of 5 beats.
        load(1, 5);
        check("n1_step", 32'(step_size), 601);
        do_beat();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_step", 32'(step_size), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_nd", 32'(note_done), 0);
        check("rst_nf", 32'(new_frequency), 0);
        base = nd_total;
        repeat (5) do_beat();
        tick();
        check("rst_no_done", 32'(nd_total - base), 0);

        // 32 back-to-back one-beat notes.
        base = nd_total;
        for (int i = 0; i < 32; i++) begin
            load(32'(i + 1), 1);
            do_beat();
        end
        tick();
        check("wrap_count", 32'(nd_total - base), 32);
        check("nd_width", 32'(nd_wide), 0);
        check("nd_nf_overlap", 32'(collide), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
